neuron_array_integrator: RTL

Time-multiplexed, parametrised membrane integrator for a core of NEURONS neurons with signed, saturating membrane potentials.
- Between ticks, accepts synaptic events, one per cycle, each targeting one neuron.
- On each tick, sweeps all neurons in order, one per cycle: applies leak, compares against threshold, emits spikes and applies the selected reset mode.
- Sits between the synapse crossbar/scheduler and the spike router in the core.

---
 rtl/neuron_array_integrator.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/neuron_array_integrator.sv
// neuron_array_integrator
//   Time-multiplexed membrane integrator for a core of NEURONS neurons.
//   Between ticks it accumulates synaptic events (one per cycle). On each tick
//   it sweeps the array one neuron per cycle, applying leak, threshold compare,
//   spike emission and the selected reset mode. All membrane arithmetic
//   saturates at the WIDTH-bit signed limits.
//
//   Optional build macro: REFRACTORY_EN adds a per-neuron refractory counter
//   of REFRAC_TICKS ticks loaded on fire.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_tick                  single-cycle pulse, starts a sweep from IDLE
//   i_syn_valid/o_syn_ready synaptic event handshake (IDLE only)
//   i_syn_neuron/weight     event target index and signed weight
//   i_leak, i_threshold     global signed leak and firing threshold
//   i_reset_value           signed load value for reset modes 0/3
//   i_reset_mode            0/3 load, 1 subtract threshold, 2 no reset
//   i_cfg_we/addr/wdata     host membrane write (IDLE only)
//   o_cfg_rdata             combinational membrane read, 0 when out of range
//   o_busy                  high during SWEEP and DONE
//   o_spike_valid/neuron    registered spike, one cycle after its neuron
//   o_done                  one-cycle pulse at end of sweep
//   o_tick_overrun          sticky, tick seen while busy
module neuron_array_integrator #(
  parameter int WIDTH        = 8,
  parameter int NEURONS      = 16,
  parameter int REFRAC_TICKS = 2,
  localparam int NW          = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic                    i_syn_valid,
  output logic                    o_syn_ready,
  input  logic [NW-1:0]           i_syn_neuron,
  input  logic signed [WIDTH-1:0] i_syn_weight,
  input  logic signed [WIDTH-1:0] i_leak,
  input  logic signed [WIDTH-1:0] i_threshold,
  input  logic signed [WIDTH-1:0] i_reset_value,
  input  logic [1:0]              i_reset_mode,
  input  logic                    i_cfg_we,
  input  logic [NW-1:0]           i_cfg_addr,
  input  logic signed [WIDTH-1:0] i_cfg_wdata,
  output logic signed [WIDTH-1:0] o_cfg_rdata,
  output logic                    o_busy,
  output logic                    o_spike_valid,
  output logic [NW-1:0]           o_spike_neuron,
  output logic                    o_done,
  output logic                    o_tick_overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [NW:0]   LP_N    = NEURONS[NW:0];
  localparam logic [NW-1:0] LP_LAST = NW'(NEURONS - 1);

  logic [1:0]              r_state;
  logic [NW-1:0]           r_idx;
  logic signed [WIDTH-1:0] r_mem [NEURONS];
  logic                    r_spike_valid;
  logic [NW-1:0]           r_spike_neuron;
  logic                    r_overrun;

  logic                    w_syn_in_range;
  logic                    w_cfg_in_range;
  logic                    w_syn_accept;
  logic signed [WIDTH-1:0] w_syn_cur;
  logic signed [WIDTH-1:0] w_syn_sum;
  logic signed [WIDTH-1:0] w_cur;
  logic signed [WIDTH-1:0] w_v;
  logic signed [WIDTH-1:0] w_sub;
  logic signed [WIDTH-1:0] w_next;
  logic                    w_fire;
  logic                    w_refrac_sweep;
  logic                    w_refrac_syn;

  // Sum is carried at WIDTH+1 bits; overflow shows as the two top bits differing.
  function automatic logic signed [WIDTH-1:0] f_sat(input logic [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
  endfunction

  assign w_syn_in_range = ({1'b0, i_syn_neuron} < LP_N);
  assign w_cfg_in_range = ({1'b0, i_cfg_addr} < LP_N);

  assign o_syn_ready  = (r_state == S_IDLE) && !i_cfg_we;
  assign w_syn_accept = i_syn_valid && o_syn_ready;

  assign w_syn_cur = w_syn_in_range ? r_mem[i_syn_neuron] : '0;
  assign w_syn_sum = f_sat({w_syn_cur[WIDTH-1], w_syn_cur} + {i_syn_weight[WIDTH-1], i_syn_weight});

  assign w_cur = r_mem[r_idx];
  assign w_v   = f_sat({w_cur[WIDTH-1], w_cur} + {i_leak[WIDTH-1], i_leak});
  assign w_sub = f_sat({w_v[WIDTH-1], w_v} - {i_threshold[WIDTH-1], i_threshold});

  always_comb begin
    w_fire = 1'b0;
    w_next = w_cur;
    if (!w_refrac_sweep) begin
      w_fire = (w_v >= i_threshold);
      if (w_fire) begin
        case (i_reset_mode)
          2'd1:    w_next = w_sub;
          2'd2:    w_next = w_v;
          default: w_next = i_reset_value;
        endcase
      end else begin
        w_next = w_v;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NEURONS; i++) r_mem[i] <= '0;
    end else if (r_state == S_IDLE) begin
      // Host write wins; syn_ready is low whenever cfg_we is high.
      if (i_cfg_we) begin
        if (w_cfg_in_range) r_mem[i_cfg_addr] <= i_cfg_wdata;
      end else if (w_syn_accept && w_syn_in_range && !w_refrac_syn) begin
        r_mem[i_syn_neuron] <= w_syn_sum;
      end
    end else if (r_state == S_SWEEP) begin
      r_mem[r_idx] <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_spike_valid  <= 1'b0;
      r_spike_neuron <= '0;
      r_overrun      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_spike_valid <= 1'b0;
          if (i_tick) begin
            r_state <= S_SWEEP;
            r_idx   <= '0;
          end
        end
        S_SWEEP: begin
          r_spike_valid <= w_fire;
          if (w_fire) r_spike_neuron <= r_idx;
          if (i_tick) r_overrun <= 1'b1;
          if (r_idx == LP_LAST) r_state <= S_DONE;
          else                  r_idx   <= r_idx + 1'b1;
        end
        S_DONE: begin
          r_spike_valid <= 1'b0;
          if (i_tick) r_overrun <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef REFRACTORY_EN
  localparam int CW = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
  localparam logic [CW-1:0] LP_LOAD = CW'(REFRAC_TICKS);

  logic [CW-1:0] r_cnt [NEURONS];

  assign w_refrac_sweep = (r_cnt[r_idx] != '0);
  assign w_refrac_syn   = w_syn_in_range ? (r_cnt[i_syn_neuron] != '0) : 1'b0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NEURONS; i++) r_cnt[i] <= '0;
    end else if (r_state == S_SWEEP) begin
      if (w_refrac_sweep) r_cnt[r_idx] <= r_cnt[r_idx] - 1'b1;
      else if (w_fire)    r_cnt[r_idx] <= LP_LOAD;
    end
  end
`else
  assign w_refrac_sweep = 1'b0;
  assign w_refrac_syn   = 1'b0;
  // REFRAC_TICKS only matters when refractory counters are built.
  logic w_unused_refrac;
  assign w_unused_refrac = (REFRAC_TICKS != 0);
`endif

  assign o_cfg_rdata    = w_cfg_in_range ? r_mem[i_cfg_addr] : '0;
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_DONE);
  assign o_spike_valid  = r_spike_valid;
  assign o_spike_neuron = r_spike_neuron;
  assign o_tick_overrun = r_overrun;

endmodule
